// File: rtl/uart_cmd_responder.sv
// Remote-end UART link: receives 3-byte command packets (8N1), sends one-byte responses.
// Latency: cmd/cmd_rdy 1 clk after byte-3 stop sample; TX falls 1 clk after send_resp.
// Backpressure: none; a new packet overwrites cmd/data, send_resp while busy is dropped.
module uart_cmd_responder #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] TX_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // ---------------- RX bit engine ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_SHIFT, RX_STOP} rx_state_t;

  rx_state_t       rx_state, rx_next;
  logic            rx_s1, rx_sync, rx_prev;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bits;
  logic [7:0]      rx_byte;
  logic            byte_vld, framing_err;
  logic            start_det;
  logic            rx_expire;

  // Counter reaches 1 on the clock where the line is sampled.
  assign rx_expire = (rx_cnt == CNT_ONE);

  // Two-flop synchronizer plus one delay flop for falling-edge detection; idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next-state: start edge, glitch rejection, 8 data samples, stop sample.
  always_comb begin
    rx_next   = rx_state;
    start_det = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_next   = RX_START;
          start_det = 1'b1;
        end
      end
      RX_START: if (rx_expire) rx_next = rx_sync ? RX_IDLE : RX_SHIFT;
      RX_SHIFT: if (rx_expire && (rx_bits == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_expire) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: bit timer, LSB-first shift register, one-cycle byte/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt      <= '0;
      rx_bits     <= '0;
      rx_byte     <= '0;
      byte_vld    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_vld    <= 1'b0;
      framing_err <= 1'b0;
      case (rx_state)
        RX_IDLE: if (start_det) rx_cnt <= HALF_CNT;
        RX_START: begin
          if (rx_expire) begin
            rx_cnt  <= FULL_CNT;
            rx_bits <= '0;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        RX_SHIFT: begin
          if (rx_expire) begin
            rx_byte <= {rx_sync, rx_byte[7:1]};
            rx_bits <= rx_bits + 3'd1;
            rx_cnt  <= FULL_CNT;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_expire) begin
            byte_vld    <= rx_sync;
            framing_err <= !rx_sync;
            rx_cnt      <= '0;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

  // ---------------- Packet assembler ----------------
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} pk_state_t;

  pk_state_t  pk_state, pk_next;
  logic       pkt_done;
  logic [7:0] shadow_cmd, shadow_hi;

  // Assembler state register.
  always_ff @(posedge clk) begin
    if (rst) pk_state <= WAIT_CMD;
    else     pk_state <= pk_next;
  end

  // Assembler next-state: each good byte advances; a framing error restarts the packet.
  always_comb begin
    pk_next  = pk_state;
    pkt_done = 1'b0;
    if (framing_err) begin
      pk_next = WAIT_CMD;
    end else if (byte_vld) begin
      case (pk_state)
        WAIT_CMD: pk_next = WAIT_HI;
        WAIT_HI:  pk_next = WAIT_LO;
        WAIT_LO: begin
          pk_next  = WAIT_CMD;
          pkt_done = 1'b1;
        end
        default:  pk_next = WAIT_CMD;
      endcase
    end
  end

  // Shadow capture and atomic output update; set of cmd_rdy beats any clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_cmd <= '0;
      shadow_hi  <= '0;
      cmd        <= '0;
      data       <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      if (framing_err) begin
        shadow_cmd <= '0;
        shadow_hi  <= '0;
      end else if (byte_vld && (pk_state == WAIT_CMD)) begin
        shadow_cmd <= rx_byte;
      end else if (byte_vld && (pk_state == WAIT_HI)) begin
        shadow_hi <= rx_byte;
      end
      if (pkt_done) begin
        cmd  <= shadow_cmd;
        data <= {shadow_hi, rx_byte};
      end
      if (pkt_done)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (start_det && (pk_state == WAIT_CMD)))
        cmd_rdy <= 1'b0;
    end
  end

  // ---------------- TX engine ----------------
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shreg;
  logic          tx_accept, tx_done;

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // TX next-state: accept only when idle; finish after the stop bit's last clock.
  always_comb begin
    tx_next   = tx_state;
    tx_accept = 1'b0;
    tx_done   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          tx_accept = 1'b1;
          tx_next   = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if ((tx_cnt == '0) && (tx_bit == 4'd9)) begin
          tx_done = 1'b1;
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX datapath: start bit driven on accept, remaining {stop, resp} shifted out LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      TX        <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shreg  <= '0;
      resp_sent <= 1'b0;
    end else if (tx_accept) begin
      TX        <= 1'b0;
      tx_shreg  <= {1'b1, resp};
      tx_cnt    <= TX_LAST;
      tx_bit    <= '0;
      resp_sent <= 1'b0;
    end else if (tx_state == TX_XMIT) begin
      if (tx_cnt == '0) begin
        if (tx_done) begin
          TX        <= 1'b1;
          tx_bit    <= '0;
          resp_sent <= 1'b1;
        end else begin
          TX       <= tx_shreg[0];
          tx_shreg <= {1'b0, tx_shreg[8:1]};
          tx_bit   <= tx_bit + 4'd1;
          tx_cnt   <= TX_LAST;
        end
      end else begin
        tx_cnt <= tx_cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Remote-end UART command responder for the quadcopter comm link. It receives a 3-byte command packet over a serial line: a command byte, then a data high byte, then a data low byte. It presents the packet to the flight controller with a ready/clear handshake. It also serializes a one-byte response (ack/status) back on its own TX line. RX and TX bit engines are self-contained. The framing is 8N1, LSB first, idle high, at a fixed clocks-per-bit rate.

## Interface
Parameters:
- BAUD_DIV, default 2604, clocks per bit (50 MHz / 19200). Must be ≥ 8. Half-bit is BAUD_DIV/2, truncated.

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- RX  input  1  asynchronous serial in, idle high
- TX  output  1  serial out, idle high
- cmd  output  8  command byte of last complete packet
- data  output  16  {high byte, low byte} of last complete packet
- cmd_rdy  output  1  packet valid flag
- clr_cmd_rdy  input  1  consumer clears cmd_rdy
- resp  input  8  response byte, sampled on send_resp
- send_resp  input  1  one-cycle request to transmit resp
- resp_sent  output  1  response frame finished; held until next accepted send_resp

## Operation
RX bit engine:
- RX passes through 2 flops, reset value 1.
- States: IDLE, START, SHIFT, STOP.
- IDLE → START on synced falling edge (prev 1, cur 0); bit counter loads BAUD_DIV/2.
- START, at counter expiry: sample synced RX. If it is 1, the edge was a glitch → IDLE, no byte. If it is 0 → SHIFT, counter reloads BAUD_DIV.
- SHIFT: sample at each expiry; shift right into bit 7; after 8 samples → STOP.
- STOP, at expiry: if sample is 1, emit internal byte_vld for 1 cycle. If sample is 0, emit framing_err for 1 cycle. Either way → IDLE.

Packet assembler:
- States: WAIT_CMD, WAIT_HI, WAIT_LO. byte_vld advances the state.
- WAIT_CMD captures a shadow cmd. WAIT_HI captures the shadow high byte.
- WAIT_LO transfers to the outputs in one cycle: cmd ← shadow cmd; data ← {shadow hi, byte}. Sets cmd_rdy; → WAIT_CMD.
- framing_err in any state → WAIT_CMD, shadows discarded, outputs untouched.
- cmd and data change only on packet completion.
- cmd_rdy clear conditions: clr_cmd_rdy, or a START entry while in WAIT_CMD (start of next packet).
- If set and clear occur on the same cycle, set wins.

TX engine:
- States: IDLE, XMIT.
- send_resp in IDLE loads shift register {1, resp, 0}, clears resp_sent, → XMIT.
- Each bit is held exactly BAUD_DIV clocks. Order: start bit, resp[0]..resp[7], stop bit.
- After the 10th bit → IDLE, resp_sent ← 1.
- send_resp while in XMIT is ignored and resp is not re-sampled.
- TX is registered. TX = 1 in IDLE.
- RX and TX operate fully independently; full duplex is allowed.

Reset (rst=1 at posedge):
- Outputs: TX=1, cmd=0, data=0, cmd_rdy=0, resp_sent=0.
- All FSMs go idle and counters clear.
- A frame in progress on either engine is aborted. The remote end sees TX high from the next cycle.

## Timing
- RX detection: a falling edge on pin RX is seen 2–3 clocks later, due to synchronizer plus edge detect.
- RX sampling: at edge + BAUD_DIV/2, then every BAUD_DIV.
- Stop-bit sample: 9·BAUD_DIV + BAUD_DIV/2 clocks after detection.
- cmd_rdy, cmd and data update on the clock after the stop-bit sample of byte 3.
- Inter-byte gaps: any length; the assembler has no timeout.
- TX start: TX falls on the clock after send_resp is sampled.
- TX frame: 10·BAUD_DIV clocks.
- resp_sent: rises 10·BAUD_DIV+1 clocks after the send_resp cycle.
- A new send_resp is accepted on the same cycle resp_sent rises.

## Test plan
1. BAUD_DIV=16; bench serializes 0xA5, 0x12, 0x34 → cmd_rdy=1, cmd=0xA5, data=0x1234 on clock after 3rd stop sample; cmd_rdy stays 1 with no clear.
2. Pulse clr_cmd_rdy → cmd_rdy=0 next clock, cmd/data hold. Then drive the start bit of 0x07 → cmd_rdy remains 0. Also assert clr_cmd_rdy on the completion cycle of the next packet → cmd_rdy=1.
3. Send 0x11, then 0x22 with stop bit 0, then 0x05, 0x00, 0xFF → one cmd_rdy only, cmd=0x05, data=0x00FF.
4. RX low pulse of 5 clocks → no byte, FSM back to IDLE. Following packet 0x80, 0x01, 0x02 decodes correctly.
5. resp=0xA5, pulse send_resp → TX=0 for 16 clocks, then 1,0,1,0,0,1,0,1 (16 clocks each), then stop high; resp_sent at clock 161. send_resp with resp=0xFF at clock 40 is ignored and frame bits are unchanged.
6. Assert rst mid-RX byte 2 and mid-TX frame → next clock TX=1, cmd_rdy=0, resp_sent=0, cmd=0, data=0. Fresh packet 0xFF, 0xFF, 0xFF → cmd=0xFF, data=0xFFFF.
